cp0_regfile_v2: RTL and testbench
=================================

// Module: cp0_regfile_v2
// PURPOSE
//  Parametrised MIPS32 CP0 register file, successor to the single-config cp0. Holds the exception,
//  timer and TLB-management registers; serves mfc0/mtc0 from the MEM stage; takes exception
//  commits and tlbp/tlbr results. Adds Random/Wired/Context/PageMask, a timer sub-block with a
//  programmable divider, and TLB-size-aware Index. Raises cp0_has_int to the exception unit.
// PARAMETERS
//  TLB_ENTRIES  16  TLB size, power of 2 in 2..64; IDX_W = $clog2(TLB_ENTRIES)
//  HW_IRQ       6   external interrupt lines mapped to Cause.IP[2+:HW_IRQ], 1..6
//  COUNT_DIV    2   core clocks per Count increment, 1..8
//  HAS_RANDOM   1   0: Random and Wired read as 0 and ignore writes
// PORTS
//  clk               in   1   clock, all state on posedge
//  rst               in   1   synchronous reset, ACTIVE-LOW (rst==0 at posedge resets)
//  interrupt         in   HW_IRQ  level-sensitive external interrupts
//  r_ena/r_addr      in   1/8 mfc0 read enable and {rd[4:0],sel[2:0]}
//  r_data            out  32  combinational read data, 0 when !r_ena or unmapped
//  w_ena/w_addr/w_data in 1/8/32  mtc0 write
//  cls_exl           in   1   eret commit: clear Status.EXL
//  exc_ena           in   1   exception commit; exc_code[4:0], exc_bd, exc_epc[31:0]
//  exc_badva_ena     in   1   with exc_badva[31:0]: load BadVAddr, Context.BadVPN2, EntryHi.VPN2
//  tlbp_ena          in   1   with tlbp_hit, tlbp_idx[IDX_W-1:0]
//  tlbr_ena          in   1   with tlbr_hi, tlbr_lo0, tlbr_lo1, tlbr_mask [31:0]
//  epc,status,cause,index,random,entryhi,entrylo0,entrylo1,pagemask  out 32  live register views
//  cp0_has_int       out  1   pending unmasked interrupt
// BEHAVIOUR
//  Reset: Status=32'h0040_0000 (BEV=1), Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, Index=0,
//   Random=TLB_ENTRIES-1, Wired=0, Context=0, PageMask=0, EntryHi/Lo0/Lo1=0; outputs follow.
//  Reads: zero latency. r_ena & w_ena & r_addr==w_addr returns w_data after the same masking
//   the register applies. Unmapped addresses read 0. Config(16,0) reads 32'h8000_0083 (MT=1, K0=3);
//   PRId(15,0) reads 32'h0001_8000.
//  Write masks: Index[IDX_W-1:0]; Random read-only; Wired[IDX_W-1:0]; EntryLo {6'h0,w[25:0]};
//   PageMask[28:13]; EntryHi {w[31:13],5'h0,w[7:0]}; Context[31:23]; Status {IM[15:8],EXL,IE};
//   Cause IP[9:8]; EPC full; BadVAddr/PRId/Config read-only.
//  Same-cycle priority, highest first: reset, exc_ena, tlbr_ena, tlbp_ena, mtc0, cls_exl.
//   exc_ena sets EXL=1, Cause.ExcCode, Cause.BD, EPC (blocks mtc0 EPC/Status that cycle).
//   cls_exl with exc_ena: exc_ena wins, EXL=1.
//  tlbp: hit -> Index={1'b0,0,tlbp_idx}; miss -> Index[31]=1 (P), low bits unchanged.
//  Random (HAS_RANDOM=1): decrement every cycle; at Wired (or below) wraps to TLB_ENTRIES-1.
//   mtc0 Wired forces Random=TLB_ENTRIES-1 next cycle. Wired >= TLB_ENTRIES-1 holds Random there.
//  Timer: divider counts 0..COUNT_DIV-1, Count++ on wrap (32-bit wrap-around). mtc0 Count loads
//   Count and clears divider. TI set on the increment that makes Count==Compare; sticky until
//   mtc0 Compare. mtc0 Compare and match in same cycle: clear wins.
//  Cause.IP[7:2] registered each cycle (1-cycle latency) from interrupt; IP7 = interrupt[5]|TI
//   (only interrupt[5] exists when HW_IRQ==6; absent lines read 0). Cause.TI = TI.
//  cp0_has_int = |(Cause.IP & Status.IM) & Status.IE & ~Status.EXL, combinational from regs.
//  Reset mid-operation: all state returns to reset values on that edge; in-flight commits dropped.
// STRUCTURE
//  cp0_pkg: register address localparams {rd,sel}, ExcCode constants, Status/Cause bit indices,
//   Config/PRId constants, reset values.
//  Sub-module cp0_timer (clk, rst, COUNT_DIV; count_we/count_wd, compare_we/compare_wd -> count,
//   compare, ti). Everything else in cp0_regfile_v2.
// TESTING
//  COUNT_DIV=2, mtc0 Compare=3, Count=0 -> TI rises 6 cycles later; IM7=1,IE=1 -> cp0_has_int=1;
//   mtc0 Compare=10 -> TI=0 next cycle.
//  TLB_ENTRIES=16, Wired=0 -> Random 15,14..0,15; mtc0 Wired=12 -> Random 15,14,13,12,15.
//  exc_ena (code=5'h4, bd=1, epc=32'hBFC0_0100) same cycle as mtc0 EPC=32'h1234 -> EPC=BFC0_0100,
//   Cause[31]=1, ExcCode=4, EXL=1; then cls_exl -> EXL=0.
//  tlbp miss -> Index=32'h8000_000X (low bits kept); tlbp hit idx=7 -> Index=7; mtc0 Index=32'hFF
//   -> reads 32'h0F.
//  interrupt[2]=1, IM4=1, IE=1, EXL=0 -> Cause.IP4 and cp0_has_int one cycle later; EXL=1 masks it.
//  rst=0 mid-timer-count with EXL=1 -> next cycle Status=0040_0000, Count=0, Random=15, has_int=0.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared constants for the MIPS32 CP0 register file: {rd,sel} addresses, field
// positions, write masks, reset values and exception codes.
package cp0_pkg;

  localparam logic [7:0] A_INDEX    = 8'h00;  // rd 0
  localparam logic [7:0] A_RANDOM   = 8'h08;  // rd 1
  localparam logic [7:0] A_ENTRYLO0 = 8'h10;  // rd 2
  localparam logic [7:0] A_ENTRYLO1 = 8'h18;  // rd 3
  localparam logic [7:0] A_CONTEXT  = 8'h20;  // rd 4
  localparam logic [7:0] A_PAGEMASK = 8'h28;  // rd 5
  localparam logic [7:0] A_WIRED    = 8'h30;  // rd 6
  localparam logic [7:0] A_BADVADDR = 8'h40;  // rd 8
  localparam logic [7:0] A_COUNT    = 8'h48;  // rd 9
  localparam logic [7:0] A_ENTRYHI  = 8'h50;  // rd 10
  localparam logic [7:0] A_COMPARE  = 8'h58;  // rd 11
  localparam logic [7:0] A_STATUS   = 8'h60;  // rd 12
  localparam logic [7:0] A_CAUSE    = 8'h68;  // rd 13
  localparam logic [7:0] A_EPC      = 8'h70;  // rd 14
  localparam logic [7:0] A_PRID     = 8'h78;  // rd 15
  localparam logic [7:0] A_CONFIG   = 8'h80;  // rd 16

  typedef enum logic [4:0] {
    EXC_INT  = 5'h00, EXC_MOD  = 5'h01, EXC_TLBL = 5'h02, EXC_TLBS = 5'h03,
    EXC_ADEL = 5'h04, EXC_ADES = 5'h05, EXC_SYS  = 5'h08, EXC_BP   = 5'h09,
    EXC_RI   = 5'h0a, EXC_CPU  = 5'h0b, EXC_OV   = 5'h0c
  } exc_code_e;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int ST_BEV = 22;
  localparam int CA_TI  = 30;
  localparam int CA_BD  = 31;

  localparam logic [31:0] STATUS_RST    = 32'h0040_0000;
  localparam logic [31:0] CONFIG_VAL    = 32'h8000_0083;
  localparam logic [31:0] PRID_VAL      = 32'h0001_8000;
  localparam logic [31:0] ENTRYLO_MASK  = 32'h03FF_FFFF;
  localparam logic [31:0] PAGEMASK_MASK = 32'h1FFF_E000;
  localparam logic [31:0] ENTRYHI_MASK  = 32'hFFFF_E0FF;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances once every COUNT_DIV clocks; TI is set by
// the increment that reaches Compare and stays set until Compare is rewritten.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic [31:0] count_wd,
  input  logic        compare_we,
  input  logic [31:0] compare_wd,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [DIV_W-1:0] div;
  logic             tick;

  assign tick = (div == DIV_W'(COUNT_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div     <= '0;
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      if (count_we) begin
        count <= count_wd;
        div   <= '0;
      end else begin
        div <= tick ? '0 : div + 1'b1;
        if (tick) count <= count + 32'd1;
      end
      if (compare_we) compare <= compare_wd;
      // Rewriting Compare acknowledges the timer even on the matching cycle.
      if (compare_we)
        ti <= 1'b0;
      else if (!count_we && tick && (count + 32'd1 == compare))
        ti <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_regfile_v2.sv
// MIPS32 CP0 register file: exception, TLB-management and timer registers with
// mfc0/mtc0 access, exception/eret commits, tlbp/tlbr updates and interrupt request.
module cp0_regfile_v2
  import cp0_pkg::*;
#(
  parameter  int TLB_ENTRIES = 16,
  parameter  int HW_IRQ      = 6,
  parameter  int COUNT_DIV   = 2,
  parameter  int HAS_RANDOM  = 1,
  localparam int IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [HW_IRQ-1:0] interrupt,
  input  logic              r_ena,
  input  logic [7:0]        r_addr,
  output logic [31:0]       r_data,
  input  logic              w_ena,
  input  logic [7:0]        w_addr,
  input  logic [31:0]       w_data,
  input  logic              cls_exl,
  input  logic              exc_ena,
  input  logic [4:0]        exc_code,
  input  logic              exc_bd,
  input  logic [31:0]       exc_epc,
  input  logic              exc_badva_ena,
  input  logic [31:0]       exc_badva,
  input  logic              tlbp_ena,
  input  logic              tlbp_hit,
  input  logic [IDX_W-1:0]  tlbp_idx,
  input  logic              tlbr_ena,
  input  logic [31:0]       tlbr_hi,
  input  logic [31:0]       tlbr_lo0,
  input  logic [31:0]       tlbr_lo1,
  input  logic [31:0]       tlbr_mask,
  output logic [31:0]       epc,
  output logic [31:0]       status,
  output logic [31:0]       cause,
  output logic [31:0]       index,
  output logic [31:0]       random,
  output logic [31:0]       entryhi,
  output logic [31:0]       entrylo0,
  output logic [31:0]       entrylo1,
  output logic [31:0]       pagemask,
  output logic              cp0_has_int
);

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(TLB_ENTRIES - 1);

  logic             index_p;
  logic [IDX_W-1:0] index_val, random_q, wired_q;
  logic [31:0]      entrylo0_q, entrylo1_q, pagemask_q, entryhi_q, badvaddr_q, epc_q;
  logic [8:0]       ctx_base;
  logic [18:0]      ctx_vpn2;
  logic [7:0]       st_im;
  logic             st_exl, st_ie;
  logic             ca_bd;
  logic [4:0]       ca_exc;
  logic [1:0]       ca_ip_sw;
  logic [5:0]       ip_hw, irq_ext;
  logic [7:0]       ip;
  logic [31:0]      count, compare, context_v, wired_v;
  logic             ti;

  logic we_index, we_wired, we_lo0, we_lo1, we_context, we_pagemask;
  logic we_entryhi, we_status, we_cause, we_epc, we_count, we_compare;

  assign we_index    = w_ena && (w_addr == A_INDEX);
  assign we_wired    = w_ena && (w_addr == A_WIRED) && (HAS_RANDOM != 0);
  assign we_lo0      = w_ena && (w_addr == A_ENTRYLO0);
  assign we_lo1      = w_ena && (w_addr == A_ENTRYLO1);
  assign we_context  = w_ena && (w_addr == A_CONTEXT);
  assign we_pagemask = w_ena && (w_addr == A_PAGEMASK);
  assign we_entryhi  = w_ena && (w_addr == A_ENTRYHI);
  assign we_status   = w_ena && (w_addr == A_STATUS);
  assign we_cause    = w_ena && (w_addr == A_CAUSE);
  assign we_epc      = w_ena && (w_addr == A_EPC);
  assign we_count    = w_ena && (w_addr == A_COUNT);
  assign we_compare  = w_ena && (w_addr == A_COMPARE);

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (we_count),
    .count_wd   (w_data),
    .compare_we (we_compare),
    .compare_wd (w_data),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  // NOTE: every variable written in always_comb is assigned a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    irq_ext             = '0;
    irq_ext[HW_IRQ-1:0] = interrupt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      index_p    <= 1'b0;
      index_val  <= '0;
      random_q   <= IDX_MAX;
      wired_q    <= '0;
      entrylo0_q <= '0;
      entrylo1_q <= '0;
      pagemask_q <= '0;
      entryhi_q  <= '0;
      badvaddr_q <= '0;
      epc_q      <= '0;
      ctx_base   <= '0;
      ctx_vpn2   <= '0;
      st_im      <= '0;
      st_exl     <= 1'b0;
      st_ie      <= 1'b0;
      ca_bd      <= 1'b0;
      ca_exc     <= '0;
      ca_ip_sw   <= '0;
      ip_hw      <= '0;
    end else begin
      ip_hw <= irq_ext;

      if (exc_ena) begin
        st_exl <= 1'b1;
        ca_bd  <= exc_bd;
        ca_exc <= exc_code;
        epc_q  <= exc_epc;
      end else begin
        if (we_status) begin
          st_im  <= w_data[15:8];
          st_exl <= w_data[ST_EXL];
          st_ie  <= w_data[ST_IE];
        end else if (cls_exl) begin
          st_exl <= 1'b0;
        end
        if (we_epc) epc_q <= w_data;
      end
      if (we_cause) ca_ip_sw <= w_data[9:8];

      if (exc_badva_ena) begin
        badvaddr_q       <= exc_badva;
        ctx_vpn2         <= exc_badva[31:13];
        entryhi_q[31:13] <= exc_badva[31:13];
      end else if (tlbr_ena) begin
        entryhi_q <= tlbr_hi & ENTRYHI_MASK;
      end else if (we_entryhi) begin
        entryhi_q <= w_data & ENTRYHI_MASK;
      end
      if (we_context) ctx_base <= w_data[31:23];

      if (tlbr_ena) begin
        entrylo0_q <= tlbr_lo0 & ENTRYLO_MASK;
        entrylo1_q <= tlbr_lo1 & ENTRYLO_MASK;
        pagemask_q <= tlbr_mask & PAGEMASK_MASK;
      end else begin
        if (we_lo0)      entrylo0_q <= w_data & ENTRYLO_MASK;
        if (we_lo1)      entrylo1_q <= w_data & ENTRYLO_MASK;
        if (we_pagemask) pagemask_q <= w_data & PAGEMASK_MASK;
      end

      if (tlbp_ena) begin
        index_p <= !tlbp_hit;
        if (tlbp_hit) index_val <= tlbp_idx;
      end else if (we_index) begin
        index_p   <= 1'b0;
        index_val <= w_data[IDX_W-1:0];
      end

      if (we_wired) wired_q <= w_data[IDX_W-1:0];
      // Random cycles through the non-wired entries only: wraps at Wired,
      // parks at the top when Wired covers everything below it.
      if (we_wired || (wired_q == IDX_MAX) || (random_q <= wired_q))
        random_q <= IDX_MAX;
      else
        random_q <= random_q - 1'b1;
    end
  end

  assign ip        = {ip_hw[5] | ti, ip_hw[4:0], ca_ip_sw};
  assign status    = STATUS_RST | {16'h0, st_im, 6'h0, st_exl, st_ie};
  assign cause     = {ca_bd, ti, 14'h0, ip, 1'b0, ca_exc, 2'b00};
  assign epc       = epc_q;
  assign index     = {index_p, {(31 - IDX_W){1'b0}}, index_val};
  assign random    = (HAS_RANDOM != 0) ? 32'(random_q) : 32'h0;
  assign wired_v   = (HAS_RANDOM != 0) ? 32'(wired_q) : 32'h0;
  assign entryhi   = entryhi_q;
  assign entrylo0  = entrylo0_q;
  assign entrylo1  = entrylo1_q;
  assign pagemask  = pagemask_q;
  assign context_v = {ctx_base, ctx_vpn2, 4'h0};

  assign cp0_has_int = (|(ip & st_im)) & st_ie & ~st_exl;

  logic [31:0] rd_cur, rd_byp;

  always_comb begin
    rd_cur = 32'h0;
    unique case (r_addr)
      A_INDEX:    rd_cur = index;
      A_RANDOM:   rd_cur = random;
      A_ENTRYLO0: rd_cur = entrylo0_q;
      A_ENTRYLO1: rd_cur = entrylo1_q;
      A_CONTEXT:  rd_cur = context_v;
      A_PAGEMASK: rd_cur = pagemask_q;
      A_WIRED:    rd_cur = wired_v;
      A_BADVADDR: rd_cur = badvaddr_q;
      A_COUNT:    rd_cur = count;
      A_ENTRYHI:  rd_cur = entryhi_q;
      A_COMPARE:  rd_cur = compare;
      A_STATUS:   rd_cur = status;
      A_CAUSE:    rd_cur = cause;
      A_EPC:      rd_cur = epc_q;
      A_PRID:     rd_cur = PRID_VAL;
      A_CONFIG:   rd_cur = CONFIG_VAL;
      default:    rd_cur = 32'h0;
    endcase

    // Same-address mtc0 forwards the value the register would hold after masking.
    rd_byp = rd_cur;
    unique case (r_addr)
      A_INDEX:    rd_byp = 32'(w_data[IDX_W-1:0]);
      A_WIRED:    rd_byp = (HAS_RANDOM != 0) ? 32'(w_data[IDX_W-1:0]) : 32'h0;
      A_ENTRYLO0: rd_byp = w_data & ENTRYLO_MASK;
      A_ENTRYLO1: rd_byp = w_data & ENTRYLO_MASK;
      A_CONTEXT:  rd_byp = {w_data[31:23], context_v[22:0]};
      A_PAGEMASK: rd_byp = w_data & PAGEMASK_MASK;
      A_ENTRYHI:  rd_byp = w_data & ENTRYHI_MASK;
      A_COUNT:    rd_byp = w_data;
      A_COMPARE:  rd_byp = w_data;
      A_STATUS:   rd_byp = STATUS_RST | {16'h0, w_data[15:8], 6'h0, w_data[1:0]};
      A_CAUSE:    rd_byp = {cause[31:10], w_data[9:8], cause[7:0]};
      A_EPC:      rd_byp = w_data;
      default:    rd_byp = rd_cur;
    endcase

    r_data = 32'h0;
    if (r_ena) r_data = (w_ena && (w_addr == r_addr)) ? rd_byp : rd_cur;
  end

endmodule

// File: tb/tb_cp0_regfile_v2.sv
// Self-checking bench for cp0_regfile_v2 (TLB_ENTRIES=16, HW_IRQ=6, COUNT_DIV=2, HAS_RANDOM=1).
module tb_cp0_regfile_v2;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  interrupt;
  logic        r_ena, w_ena, cls_exl, exc_ena, exc_bd, exc_badva_ena;
  logic        tlbp_ena, tlbp_hit, tlbr_ena;
  logic [7:0]  r_addr, w_addr;
  logic [31:0] r_data, w_data, exc_epc, exc_badva;
  logic [4:0]  exc_code;
  logic [3:0]  tlbp_idx;
  logic [31:0] tlbr_hi, tlbr_lo0, tlbr_lo1, tlbr_mask;
  logic [31:0] epc, status, cause, index, random, entryhi, entrylo0, entrylo1, pagemask;
  logic        cp0_has_int;

  cp0_regfile_v2 #(.TLB_ENTRIES(16), .HW_IRQ(6), .COUNT_DIV(2), .HAS_RANDOM(1)) dut (
    .clk(clk), .rst(rst), .interrupt(interrupt),
    .r_ena(r_ena), .r_addr(r_addr), .r_data(r_data),
    .w_ena(w_ena), .w_addr(w_addr), .w_data(w_data),
    .cls_exl(cls_exl), .exc_ena(exc_ena), .exc_code(exc_code), .exc_bd(exc_bd),
    .exc_epc(exc_epc), .exc_badva_ena(exc_badva_ena), .exc_badva(exc_badva),
    .tlbp_ena(tlbp_ena), .tlbp_hit(tlbp_hit), .tlbp_idx(tlbp_idx),
    .tlbr_ena(tlbr_ena), .tlbr_hi(tlbr_hi), .tlbr_lo0(tlbr_lo0), .tlbr_lo1(tlbr_lo1),
    .tlbr_mask(tlbr_mask),
    .epc(epc), .status(status), .cause(cause), .index(index), .random(random),
    .entryhi(entryhi), .entrylo0(entrylo0), .entrylo1(entrylo1), .pagemask(pagemask),
    .cp0_has_int(cp0_has_int)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [7:0]  addr;
    logic [31:0] exp;
  } sb_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];
  sb_t  sb[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    w_ena = 1'b1; w_addr = a; w_data = d;
    tick();
    w_ena = 1'b0;
  endtask

  task automatic mfc0(input string name, input logic [7:0] a, input logic [31:0] exp);
    r_ena = 1'b1; r_addr = a;
    #1;
    check(name, r_data, exp);
  endtask

  initial begin
    logic [31:0] exp_rand;
    sb_t         e;

    rst = 1'b0; interrupt = '0; r_ena = 0; r_addr = 0; w_ena = 0; w_addr = 0; w_data = 0;
    cls_exl = 0; exc_ena = 0; exc_code = 0; exc_bd = 0; exc_epc = 0;
    exc_badva_ena = 0; exc_badva = 0; tlbp_ena = 0; tlbp_hit = 0; tlbp_idx = 0;
    tlbr_ena = 0; tlbr_hi = 0; tlbr_lo0 = 0; tlbr_lo1 = 0; tlbr_mask = 0;
    repeat (2) tick();

    check("rst_status", status, 32'h0040_0000);
    check("rst_cause", cause, 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_index", index, 32'h0);
    check("rst_random", random, 32'd15);
    check("rst_entryhi", entryhi, 32'h0);
    check("rst_has_int", {31'h0, cp0_has_int}, 32'h0);
    mfc0("rst_count", 8'h48, 32'h0);
    mfc0("rd_config", 8'h80, 32'h8000_0083);
    mfc0("rd_prid", 8'h78, 32'h0001_8000);

    // Random with Wired=0: 15,14..0,15
    rst = 1'b1;
    exp_rand = 32'd15;
    for (int i = 0; i < 17; i++) begin
      check($sformatf("random_w0_%0d", i), random, exp_rand);
      exp_rand = (exp_rand == 0) ? 32'd15 : exp_rand - 1;
      tick();
    end
    // Wired=12: 15,14,13,12,15
    mtc0(8'h30, 32'd12);
    exp_rand = 32'd15;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("random_w12_%0d", i), random, exp_rand);
      exp_rand = (exp_rand <= 12) ? 32'd15 : exp_rand - 1;
      tick();
    end

    // Write-mask table: bypass checked in the write cycle, readback from the scoreboard later
    vecs.push_back('{"index",    8'h00, 32'hFFFF_FFFF, 32'h0000_000F});
    vecs.push_back('{"wired",    8'h30, 32'hFFFF_FFF3, 32'h0000_0003});
    vecs.push_back('{"entrylo0", 8'h10, 32'hFFFF_FFFF, 32'h03FF_FFFF});
    vecs.push_back('{"entrylo1", 8'h18, 32'h1234_5678, 32'h0234_5678});
    vecs.push_back('{"context",  8'h20, 32'hFFFF_FFFF, 32'hFF80_0000});
    vecs.push_back('{"pagemask", 8'h28, 32'hFFFF_FFFF, 32'h1FFF_E000});
    vecs.push_back('{"entryhi",  8'h50, 32'hFFFF_FFFF, 32'hFFFF_E0FF});
    vecs.push_back('{"epc",      8'h70, 32'hDEAD_BEEF, 32'hDEAD_BEEF});
    vecs.push_back('{"status",   8'h60, 32'hFFFF_FFFF, 32'h0040_FF03});
    vecs.push_back('{"cause",    8'h68, 32'hFFFF_FFFF, 32'h0000_0300});
    vecs.push_back('{"compare",  8'h58, 32'h0000_1000, 32'h0000_1000});
    vecs.push_back('{"badvaddr", 8'h40, 32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{"prid",     8'h78, 32'h0000_0000, 32'h0001_8000});
    vecs.push_back('{"config",   8'h80, 32'h0000_0000, 32'h8000_0083});
    vecs.push_back('{"unmapped", 8'hF8, 32'hFFFF_FFFF, 32'h0000_0000});
    for (int i = 0; i < vecs.size(); i++) begin
      w_ena = 1'b1; w_addr = vecs[i].addr; w_data = vecs[i].wdata;
      r_ena = 1'b1; r_addr = vecs[i].addr;
      #1;
      check({"byp_", vecs[i].name}, r_data, vecs[i].exp);
      sb.push_back('{vecs[i].name, vecs[i].addr, vecs[i].exp});
      tick();
    end
    w_ena = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mfc0({"rb_", e.name}, e.addr, e.exp);
    end
    r_ena = 1'b0; r_addr = 8'h78;
    #1;
    check("rd_disabled", r_data, 32'h0);
    mtc0(8'h60, 32'h0);
    mtc0(8'h68, 32'h0);

    // Timer: Compare=3, Count=0 -> TI six cycles later
    mtc0(8'h58, 32'd3);
    mtc0(8'h48, 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("ti_low_%0d", k), {31'h0, cause[30]}, 32'h0);
    end
    tick();
    check("ti_rise", {31'h0, cause[30]}, 32'h1);
    mfc0("count_at_ti", 8'h48, 32'd3);
    mtc0(8'h60, 32'h0000_8001);
    check("ti_has_int", {31'h0, cp0_has_int}, 32'h1);
    mtc0(8'h58, 32'd10);
    check("ti_clear", {31'h0, cause[30]}, 32'h0);
    check("ti_clear_int", {31'h0, cp0_has_int}, 32'h0);
    // Compare rewritten on the matching increment: clear wins
    mtc0(8'h58, 32'd2);
    mtc0(8'h48, 32'd0);
    repeat (3) tick();
    mtc0(8'h58, 32'd2);
    check("ti_clear_wins", {31'h0, cause[30]}, 32'h0);
    mfc0("count_clr_wins", 8'h48, 32'd2);
    tick();
    check("ti_stays_low", {31'h0, cause[30]}, 32'h0);
    mtc0(8'h60, 32'h0);
    mtc0(8'h58, 32'hFFFF_0000);

    // tlbp / tlbr
    tlbp_ena = 1; tlbp_hit = 0; tlbp_idx = 4'd3;
    tick();
    check("tlbp_miss", index, 32'h8000_000F);
    tlbp_hit = 1; tlbp_idx = 4'd7;
    tick();
    check("tlbp_hit", index, 32'h0000_0007);
    tlbp_idx = 4'd2; w_ena = 1; w_addr = 8'h00; w_data = 32'd9;
    tick();
    tlbp_ena = 0; w_ena = 0;
    check("tlbp_over_mtc0", index, 32'h0000_0002);
    tlbr_ena = 1; tlbr_hi = 32'hAAAA_AAAA; tlbr_lo0 = 32'hAAAA_AAAA;
    tlbr_lo1 = 32'h5555_5555; tlbr_mask = 32'hAAAA_AAAA;
    tick();
    tlbr_ena = 0;
    check("tlbr_hi", entryhi, 32'hAAAA_A0AA);
    check("tlbr_lo0", entrylo0, 32'h02AA_AAAA);
    check("tlbr_lo1", entrylo1, 32'h0155_5555);
    check("tlbr_mask", pagemask, 32'h0AAA_A000);

    // Exception commit beats same-cycle mtc0 EPC
    exc_ena = 1; exc_code = 5'h4; exc_bd = 1; exc_epc = 32'hBFC0_0100;
    exc_badva_ena = 1; exc_badva = 32'h1234_5678;
    w_ena = 1; w_addr = 8'h70; w_data = 32'h0000_1234;
    tick();
    exc_ena = 0; exc_badva_ena = 0; w_ena = 0;
    check("exc_epc", epc, 32'hBFC0_0100);
    check("exc_bd", {31'h0, cause[31]}, 32'h1);
    check("exc_code", {27'h0, cause[6:2]}, 32'h4);
    check("exc_exl", {31'h0, status[1]}, 32'h1);
    mfc0("exc_badvaddr", 8'h40, 32'h1234_5678);
    mfc0("exc_context", 8'h20, 32'hFF89_1A20);
    check("exc_entryhi", entryhi, 32'h1234_40AA);
    cls_exl = 1;
    tick();
    check("eret_exl", {31'h0, status[1]}, 32'h0);
    exc_ena = 1;
    tick();
    exc_ena = 0;
    check("exc_over_eret", {31'h0, status[1]}, 32'h1);
    tick();
    cls_exl = 0;
    check("eret_again", {31'h0, status[1]}, 32'h0);

    // External interrupt on line 2 -> IP4, one cycle latency
    mtc0(8'h60, 32'h0000_1001);
    interrupt = 6'b000100;
    #1;
    check("ip4_not_yet", {31'h0, cause[12]}, 32'h0);
    tick();
    check("ip4_set", {31'h0, cause[12]}, 32'h1);
    check("ip4_has_int", {31'h0, cp0_has_int}, 32'h1);
    mtc0(8'h60, 32'h0000_1003);
    check("ip4_exl_mask", {31'h0, cp0_has_int}, 32'h0);

    // Reset mid-operation with EXL=1
    rst = 1'b0;
    tick();
    check("rst2_status", status, 32'h0040_0000);
    mfc0("rst2_count", 8'h48, 32'h0);
    check("rst2_random", random, 32'd15);
    check("rst2_has_int", {31'h0, cp0_has_int}, 32'h0);
    check("rst2_cause", cause, 32'h0);
    rst = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
